// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing and scene colour constants.
package vga_pkg;

   // Timing in pixel-clock ticks / lines
   localparam int H_TOTAL   = 800;
   localparam int V_TOTAL   = 521;
   localparam int H_SYNC    = 96;
   localparam int V_SYNC    = 2;
   localparam int H_ACT_INI = 144;
   localparam int H_ACT_FIN = 784;
   localparam int V_ACT_INI = 31;
   localparam int V_ACT_FIN = 511;
   localparam int H_VISIBLE = H_ACT_FIN - H_ACT_INI;
   localparam int V_VISIBLE = V_ACT_FIN - V_ACT_INI;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } color_t;

   localparam color_t COL_PAJARO = color_t'(8'b111_011_00);
   localparam color_t COL_TUBO   = color_t'(8'b000_111_01);
   localparam color_t COL_FONDO  = color_t'(8'b000_000_00);
   localparam color_t COL_FIN    = color_t'(8'b111_000_00);

   // Zero-extend a 10-bit coordinate into the 11-bit signed compare domain
   function automatic logic signed [10:0] a_signed(input logic [9:0] v);
      return $signed({1'b0, v});
   endfunction

endpackage

// File: rtl/vga_contador.sv
// Horizontal/vertical scan counters, raw active-low syncs and frame-wrap strobe.
module vga_contador
   import vga_pkg::*;
(
   input  logic       dclk,
   input  logic       clr,
   output logic [9:0] hc,
   output logic [9:0] vc,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       fin_cuadro
);

   logic fin_linea;

   assign fin_linea  = (hc == 10'(H_TOTAL - 1));
   assign fin_cuadro = fin_linea && (vc == 10'(V_TOTAL - 1));
   assign hsync_raw  = ~(hc < 10'(H_SYNC));
   assign vsync_raw  = ~(vc < 10'(V_SYNC));

   // Scan counters: hc wraps every line, vc advances on each hc wrap
   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         hc <= '0;
         vc <= '0;
      end else if (fin_linea) begin
         hc <= '0;
         vc <= (vc == 10'(V_TOTAL - 1)) ? '0 : vc + 10'd1;
      end else begin
         hc <= hc + 10'd1;
      end
   end

endmodule

// File: rtl/dibujar_escena_param.sv
// Scene renderer: pipes and bird over a VGA scan, with frame-latched inputs,
// a two-stage output pipeline and per-frame collision detection.
module dibujar_escena_param
   import vga_pkg::*;
#(
   parameter int N_TUBOS    = 2,
   parameter int ANCHO_TUBO = 64,
   parameter int HUECO      = 128,
   parameter int PAJ_X      = 128,
   parameter int PAJ_W      = 32,
   parameter int PAJ_H      = 32
) (
   input  logic                   dclk,
   input  logic                   clr,
   input  logic [10*N_TUBOS-1:0]  pos_h_tubos,
   input  logic [10*N_TUBOS-1:0]  pos_v_tubos,
   input  logic [9:0]             pos_v_pajaro,
   input  logic                   chocar,
   output logic                   hsync,
   output logic                   vsync,
   output logic [2:0]             red,
   output logic [2:0]             green,
   output logic [1:0]             blue,
   output logic                   inicio_cuadro,
   output logic                   colision
);

   localparam logic signed [10:0] ANCHO_S  = 11'(ANCHO_TUBO);
   localparam logic signed [10:0] HUECO_S  = 11'(HUECO);
   localparam logic signed [10:0] PAJ_X0_S = 11'(PAJ_X);
   localparam logic signed [10:0] PAJ_X1_S = 11'(PAJ_X + PAJ_W);
   localparam logic signed [10:0] PAJ_H_S  = 11'(PAJ_H);

   logic [9:0] hc, vc;
   logic       hs_raw, vs_raw, fin;

   vga_contador u_contador (
      .dclk       (dclk),
      .clr        (clr),
      .hc         (hc),
      .vc         (vc),
      .hsync_raw  (hs_raw),
      .vsync_raw  (vs_raw),
      .fin_cuadro (fin)
   );

   logic [10*N_TUBOS-1:0] sh_h, sh_v;
   logic [9:0]            sh_vb;
   logic                  sh_chocar;

   // Shadow registers: inputs only take effect at the frame wrap
   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         sh_h      <= '0;
         sh_v      <= '0;
         sh_vb     <= '0;
         sh_chocar <= 1'b0;
      end else if (fin) begin
         sh_h      <= pos_h_tubos;
         sh_v      <= pos_v_tubos;
         sh_vb     <= pos_v_pajaro;
         sh_chocar <= chocar;
      end
   end

   logic                activo;
   logic signed [10:0]  x, y, vb;
   logic [N_TUBOS-1:0]  hit_tubo;
   logic                hit_pajaro;

   assign activo = (hc >= 10'(H_ACT_INI)) && (hc < 10'(H_ACT_FIN)) &&
                   (vc >= 10'(V_ACT_INI)) && (vc < 10'(V_ACT_FIN));
   assign x  = a_signed(hc) - 11'(H_ACT_INI);
   assign y  = a_signed(vc) - 11'(V_ACT_INI);
   assign vb = a_signed(sh_vb);

   for (genvar k = 0; k < N_TUBOS; k++) begin : g_tubo
      logic signed [10:0] h_k, v_k;
      assign h_k = a_signed(sh_h[10*k +: 10]);
      assign v_k = a_signed(sh_v[10*k +: 10]);
      // A pipe parked at x >= 640 is hidden; V < HUECO leaves no upper segment
      assign hit_tubo[k] = (sh_h[10*k +: 10] < 10'(H_VISIBLE)) &&
                           (x >= h_k) && (x <= h_k + ANCHO_S) &&
                           ((y >= v_k) || (y < v_k - HUECO_S));
   end

   assign hit_pajaro = (x > PAJ_X0_S) && (x <= PAJ_X1_S) && (y >= vb - PAJ_H_S) && (y <= vb);

   logic v1, act1, bird1, pipe1, hs1, vs1, ch1;

   // Stage 1: per-pixel hit flags and raw syncs
   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         v1    <= 1'b0;
         act1  <= 1'b0;
         bird1 <= 1'b0;
         pipe1 <= 1'b0;
         hs1   <= 1'b1;
         vs1   <= 1'b1;
         ch1   <= 1'b0;
      end else begin
         v1    <= 1'b1;
         act1  <= activo;
         bird1 <= hit_pajaro;
         pipe1 <= |hit_tubo;
         hs1   <= hs_raw;
         vs1   <= vs_raw;
         ch1   <= sh_chocar;
      end
   end

   color_t color_d, color_q;

   // Colour priority: blanking, game-over, bird, pipe, background
   always_comb begin
      color_d = COL_FONDO;
      if (!(v1 && act1)) color_d = COL_FONDO;
      else if (ch1)      color_d = COL_FIN;
      else if (bird1)    color_d = COL_PAJARO;
      else if (pipe1)    color_d = COL_TUBO;
   end

   // Stage 2: registered colour and syncs
   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         color_q <= COL_FONDO;
         hsync   <= 1'b1;
         vsync   <= 1'b1;
      end else begin
         color_q <= color_d;
         hsync   <= hs1;
         vsync   <= vs1;
      end
   end

   assign red   = color_q.r;
   assign green = color_q.g;
   assign blue  = color_q.b;

   logic pend, pend_set;

   assign pend_set = (v1 && act1 && bird1 && pipe1) ||
                     (sh_vb < 10'(PAJ_H)) || (sh_vb > 10'(V_VISIBLE - 1));

   // Collision accumulator: pend gathers the frame, colision publishes it at the wrap
   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         pend          <= 1'b0;
         colision      <= 1'b0;
         inicio_cuadro <= 1'b0;
      end else begin
         inicio_cuadro <= fin;
         if (fin) begin
            colision <= pend | pend_set;
            pend     <= 1'b0;
         end else if (pend_set) begin
            pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dibujar_escena_param.sv
// Directed bench for dibujar_escena_param: frame-by-frame scene, sync, collision and reset checks.
module tb_dibujar_escena_param;

   localparam int         LIMIT = 2 * 416800 + 1000;
   localparam logic [7:0] BLK   = 8'b000_000_00;
   localparam logic [7:0] BIRD  = 8'b111_011_00;
   localparam logic [7:0] PIPE  = 8'b000_111_01;
   localparam logic [7:0] OVER  = 8'b111_000_00;

   logic        dclk = 1'b0;
   logic        clr;
   logic [19:0] pos_h_tubos, pos_v_tubos;
   logic [9:0]  pos_v_pajaro;
   logic        chocar;
   logic        hsync, vsync, inicio_cuadro, colision;
   logic [2:0]  red, green;
   logic [1:0]  blue;
   logic [7:0]  rgb;

   int checks = 0;
   int errors = 0;
   int m_hc, m_vc;
   int hs_low = 0, vs_low = 0, ini_cnt = 0;
   int hs0, vs0, ini0;

   assign rgb = {red, green, blue};

   dibujar_escena_param #(
      .N_TUBOS    (2),
      .ANCHO_TUBO (64),
      .HUECO      (128),
      .PAJ_X      (128),
      .PAJ_W      (32),
      .PAJ_H      (32)
   ) dut (
      .dclk          (dclk),
      .clr           (clr),
      .pos_h_tubos   (pos_h_tubos),
      .pos_v_tubos   (pos_v_tubos),
      .pos_v_pajaro  (pos_v_pajaro),
      .chocar        (chocar),
      .hsync         (hsync),
      .vsync         (vsync),
      .red           (red),
      .green         (green),
      .blue          (blue),
      .inicio_cuadro (inicio_cuadro),
      .colision      (colision)
   );

   always #20 dclk = ~dclk;

   // Reference scan position
   always @(posedge dclk or posedge clr) begin
      if (clr) begin
         m_hc <= 0;
         m_vc <= 0;
      end else if (m_hc == 799) begin
         m_hc <= 0;
         m_vc <= (m_vc == 520) ? 0 : m_vc + 1;
      end else begin
         m_hc <= m_hc + 1;
      end
   end

   // Running totals of low sync cycles and frame pulses
   always @(posedge dclk) begin
      if (!clr) begin
         if (hsync === 1'b0) hs_low = hs_low + 1;
         if (vsync === 1'b0) vs_low = vs_low + 1;
         if (inicio_cuadro === 1'b1) ini_cnt = ini_cnt + 1;
      end
   end

   // Advance to the negedge where the reference counter equals (h,v)
   task automatic goto_cnt(input int h, input int v);
      int n = 0;
      @(negedge dclk);
      while (!(m_hc == h && m_vc == v) && n < LIMIT) begin
         @(negedge dclk);
         n++;
      end
      if (n >= LIMIT) begin
         checks++;
         errors++;
         $display("FAIL goto: position (%0d,%0d) never reached", h, v);
      end
   endtask

   // Advance to where the output for counter (h,v) is visible (two clocks later)
   task automatic goto_out(input int h, input int v);
      int h2 = h + 2;
      int v2 = v;
      if (h2 >= 800) begin
         h2 -= 800;
         v2 = (v == 520) ? 0 : v + 1;
      end
      goto_cnt(h2, v2);
   endtask

   task automatic test_reset();
      clr          = 1'b1;
      chocar       = 1'b0;
      pos_h_tubos  = {10'd1000, 10'd200};
      pos_v_tubos  = {10'd300, 10'd300};
      pos_v_pajaro = 10'd200;
      repeat (3) @(negedge dclk);
      checks++;
      if (rgb !== BLK) begin errors++; $display("FAIL reset_rgb: got %b want %b", rgb, BLK); end
      checks++;
      if ({hsync, vsync} !== 2'b11) begin
         errors++; $display("FAIL reset_sync: got %b want 11", {hsync, vsync});
      end
      checks++;
      if ({inicio_cuadro, colision} !== 2'b00) begin
         errors++; $display("FAIL reset_flags: got %b want 00", {inicio_cuadro, colision});
      end
      clr = 1'b0;
   endtask

   // Frame 0 renders from all-zero shadows: pipes at x 0..64 full height, bird at y 0
   task automatic test_first_frame();
      int         xs [6];
      int         ys [6];
      logic [7:0] cs [6];
      xs = '{150, 150, 10, 64, 65, 210};
      ys = '{0, 1, 10, 10, 10, 350};
      cs = '{BIRD, BLK, PIPE, PIPE, BLK, BLK};
      for (int i = 0; i < 6; i++) begin
         goto_out(xs[i] + 144, ys[i] + 31);
         checks++;
         if (rgb !== cs[i]) begin
            errors++;
            $display("FAIL first_frame (%0d,%0d): got %b want %b", xs[i], ys[i], rgb, cs[i]);
         end
      end
   endtask

   task automatic test_wrap(input logic exp_col, input int frame);
      goto_cnt(0, 0);
      checks++;
      if (inicio_cuadro !== 1'b1) begin
         errors++; $display("FAIL wrap%0d_inicio: got %b want 1", frame, inicio_cuadro);
      end
      checks++;
      if (colision !== exp_col) begin
         errors++; $display("FAIL wrap%0d_colision: got %b want %b", frame, colision, exp_col);
      end
      @(negedge dclk);
      checks++;
      if (inicio_cuadro !== 1'b0) begin
         errors++; $display("FAIL wrap%0d_inicio_width: got %b want 0", frame, inicio_cuadro);
      end
   endtask

   task automatic test_timing_start();
      goto_cnt(5, 0);
      hs0  = hs_low;
      vs0  = vs_low;
      ini0 = ini_cnt;
   endtask

   task automatic test_timing_end();
      goto_cnt(5, 0);
      checks++;
      if (hs_low - hs0 !== 100032) begin
         errors++; $display("FAIL timing_hsync: got %0d want 100032", hs_low - hs0);
      end
      checks++;
      if (vs_low - vs0 !== 3200) begin
         errors++; $display("FAIL timing_vsync: got %0d want 3200", vs_low - vs0);
      end
      checks++;
      if (ini_cnt - ini0 !== 2) begin
         errors++; $display("FAIL timing_inicio: got %0d want 2", ini_cnt - ini0);
      end
   endtask

   task automatic test_sync_edges();
      int   hs [4];
      int   vs [4];
      logic es [4];
      logic sel [4];
      hs  = '{10, 10, 95, 96};
      vs  = '{1, 2, 100, 100};
      es  = '{1'b0, 1'b1, 1'b0, 1'b1};
      sel = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         goto_out(hs[i], vs[i]);
         checks++;
         if ((sel[i] ? vsync : hsync) !== es[i]) begin
            errors++;
            $display("FAIL sync_edge %s at (%0d,%0d): got %b want %b", sel[i] ? "vsync" : "hsync",
                     hs[i], vs[i], sel[i] ? vsync : hsync, es[i]);
         end
      end
   endtask

   // Shadows H0=200 V0=300 Vb=200
   task automatic test_pixels();
      int         xs [12];
      int         ys [12];
      logic [7:0] cs [12];
      xs = '{210, 150, 150, 210, 210, 128, 129, 150, 160, 161, 150, 150};
      ys = '{100, 167, 168, 171, 172, 190, 190, 190, 190, 190, 200, 201};
      cs = '{PIPE, BLK, BIRD, PIPE, BLK, BLK, BIRD, BIRD, BIRD, BLK, BIRD, BLK};
      for (int i = 0; i < 12; i++) begin
         goto_out(xs[i] + 144, ys[i] + 31);
         checks++;
         if (rgb !== cs[i]) begin
            errors++;
            $display("FAIL pixel (%0d,%0d): got %b want %b", xs[i], ys[i], rgb, cs[i]);
         end
      end
   endtask

   task automatic test_tearing();
      int         xs [6];
      logic [7:0] cs [6];
      int         ys [6];
      goto_cnt(0, 250);
      pos_h_tubos[9:0] = 10'd300;
      xs = '{210, 200, 210, 264, 265, 310};
      ys = '{250, 350, 350, 350, 350, 350};
      cs = '{BLK, PIPE, PIPE, PIPE, BLK, BLK};
      for (int i = 0; i < 6; i++) begin
         goto_out(xs[i] + 144, ys[i] + 31);
         checks++;
         if (rgb !== cs[i]) begin
            errors++;
            $display("FAIL tearing_old (%0d,%0d): got %b want %b", xs[i], ys[i], rgb, cs[i]);
         end
      end
   endtask

   task automatic test_tearing_next();
      int         xs [4];
      logic [7:0] cs [4];
      xs = '{210, 300, 364, 365};
      cs = '{BLK, PIPE, PIPE, BLK};
      for (int i = 0; i < 4; i++) begin
         goto_out(xs[i] + 144, 350 + 31);
         checks++;
         if (rgb !== cs[i]) begin
            errors++;
            $display("FAIL tearing_new (%0d,350): got %b want %b", xs[i], rgb, cs[i]);
         end
      end
      pos_h_tubos[9:0] = 10'd130;
      pos_v_tubos[9:0] = 10'd180;
      chocar           = 1'b1;
   endtask

   // Raw counter positions; game-over paints only the active area
   task automatic test_game_over();
      int         hs [9];
      int         vs [9];
      logic [7:0] cs [9];
      hs = '{300, 143, 144, 100, 790, 294, 354, 783, 784};
      vs = '{5, 31, 31, 100, 100, 221, 381, 510, 510};
      cs = '{BLK, BLK, OVER, BLK, BLK, OVER, OVER, OVER, BLK};
      for (int i = 0; i < 9; i++) begin
         goto_out(hs[i], vs[i]);
         checks++;
         if (rgb !== cs[i]) begin
            errors++;
            $display("FAIL game_over hc=%0d vc=%0d: got %b want %b", hs[i], vs[i], rgb, cs[i]);
         end
      end
      pos_h_tubos[9:0] = 10'd400;
      chocar           = 1'b0;
   endtask

   task automatic test_after_move();
      goto_out(150 + 144, 190 + 31);
      checks++;
      if (rgb !== BIRD) begin errors++; $display("FAIL moved_bird: got %b want %b", rgb, BIRD); end
      goto_out(410 + 144, 350 + 31);
      checks++;
      if (rgb !== PIPE) begin errors++; $display("FAIL moved_pipe: got %b want %b", rgb, PIPE); end
      pos_v_pajaro = 10'd10;
   endtask

   // Vb=10: bird spans y -22..10, clipped at top, nothing near the bottom
   task automatic test_clip();
      int         xs [6];
      int         ys [6];
      logic [7:0] cs [6];
      xs = '{150, 128, 129, 150, 150, 150};
      ys = '{0, 5, 5, 10, 11, 479};
      cs = '{BIRD, BLK, BIRD, BIRD, BLK, BLK};
      for (int i = 0; i < 6; i++) begin
         goto_out(xs[i] + 144, ys[i] + 31);
         checks++;
         if (rgb !== cs[i]) begin
            errors++;
            $display("FAIL clip (%0d,%0d): got %b want %b", xs[i], ys[i], rgb, cs[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      goto_out(150 + 144, 5 + 31);
      checks++;
      if (rgb !== BIRD) begin errors++; $display("FAIL pre_clr_rgb: got %b want %b", rgb, BIRD); end
      #5 clr = 1'b1;
      #1;
      checks++;
      if (rgb !== BLK) begin errors++; $display("FAIL clr_rgb: got %b want %b", rgb, BLK); end
      checks++;
      if ({hsync, vsync, inicio_cuadro, colision} !== 4'b1100) begin
         errors++;
         $display("FAIL clr_outputs: got %b want 1100", {hsync, vsync, inicio_cuadro, colision});
      end
      repeat (3) @(negedge dclk);
      clr = 1'b0;
      goto_out(0, 0);
      checks++;
      if ({hsync, vsync, colision} !== 3'b000) begin
         errors++; $display("FAIL restart_sync: got %b want 000", {hsync, vsync, colision});
      end
      goto_out(150 + 144, 0 + 31);
      checks++;
      if (rgb !== BIRD) begin errors++; $display("FAIL restart_bird: got %b want %b", rgb, BIRD); end
      goto_out(10 + 144, 10 + 31);
      checks++;
      if (rgb !== PIPE) begin errors++; $display("FAIL restart_pipe: got %b want %b", rgb, PIPE); end
   endtask

   initial begin
      test_reset();
      test_first_frame();      // frame 0
      test_wrap(1'b1, 1);      // Vb shadow 0 is out of range
      test_timing_start();
      test_sync_edges();
      test_pixels();           // frame 1
      test_tearing();
      test_wrap(1'b0, 2);
      test_tearing_next();     // frame 2
      test_wrap(1'b0, 3);
      test_timing_end();
      test_game_over();        // frame 3, bird overlaps pipe
      test_wrap(1'b1, 4);
      test_after_move();       // frame 4
      test_wrap(1'b0, 5);
      test_clip();             // frame 5
      test_wrap(1'b1, 6);
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
